// File: rtl/booth_pkg.sv
// ---------------------------------------------------------------------------
// booth_pkg
// Shared definitions for the Booth multiply/divide datapath.
//   N_DEF   : default operand width (dividend 2N, divisor/quotient/remainder N)
//   state_e : divider sequencer states S_IDLE / S_CALC / S_FIX
// ---------------------------------------------------------------------------
package booth_pkg;

    localparam int N_DEF = 6;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } state_e;

endpackage : booth_pkg

// File: rtl/twos_abs.sv
// ---------------------------------------------------------------------------
// twos_abs
// Combinational conditional two's-complement negate.
// With neg_i tied to the operand MSB it yields the unsigned magnitude;
// with neg_i tied to a sign condition it applies a result sign.
//   val_i : W-bit operand
//   neg_i : 1 = negate, 0 = pass through
//   res_o : W-bit result
// ---------------------------------------------------------------------------
module twos_abs #(
    parameter int W = 6
) (
    input  logic [W-1:0] val_i,
    input  logic         neg_i,
    output logic [W-1:0] res_o
);

    // Negation wraps modulo 2^W, so the most negative value maps onto its
    // correct unsigned magnitude 2^(W-1).
    assign res_o = neg_i ? (~val_i + {{(W-1){1'b0}}, 1'b1}) : val_i;

endmodule : twos_abs

// File: rtl/booth_div.sv
// ---------------------------------------------------------------------------
// booth_div
// Sequential signed restoring divider: 2N-bit dividend / N-bit divisor.
// Quotient truncates toward zero; remainder takes the dividend's sign.
//   clk, rst    : clock, synchronous active-high reset
//   start       : request, only honoured in S_IDLE
//   dividend    : 2N-bit signed, sampled on the accept edge
//   divisor     : N-bit signed, sampled on the accept edge
//   busy        : operation in progress (S_CALC or S_FIX)
//   done        : one-cycle pulse, results valid from this cycle on
//   quotient    : N-bit signed quotient
//   remainder   : N-bit signed remainder
//   div_by_zero : last completed operation had a zero divisor
//   overflow    : true quotient did not fit signed N bits
// ---------------------------------------------------------------------------
module booth_div
    import booth_pkg::*;
#(
    parameter int N = N_DEF
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [2*N-1:0] dividend,
    input  logic [N-1:0]   divisor,
    output logic           busy,
    output logic           done,
    output logic [N-1:0]   quotient,
    output logic [N-1:0]   remainder,
    output logic           div_by_zero,
    output logic           overflow
);

    localparam int CW = $clog2(2 * N);
    localparam logic [CW-1:0]    CNT_LAST = CW'(2 * N - 1);
    // Largest quotient magnitude allowed for a positive / negative result.
    localparam logic [2*N-1:0]   LIM_POS  = (2*N)'((1 << (N - 1)) - 1);
    localparam logic [2*N-1:0]   LIM_NEG  = (2*N)'(1 << (N - 1));

    state_e         state_q, state_d;
    logic           sgn_dvd_q, sgn_dvd_d;
    logic           sgn_dsr_q, sgn_dsr_d;
    logic           zero_q, zero_d;
    logic [2*N-1:0] dvd_q, dvd_d;
    logic [2*N-1:0] quo_q, quo_d;
    logic [N:0]     part_q, part_d;
    logic [N-1:0]   dsr_q, dsr_d;
    logic [CW-1:0]  cnt_q, cnt_d;

    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic [N-1:0]   quot_q, quot_d;
    logic [N-1:0]   rem_q, rem_d;
    logic           dbz_q, dbz_d;
    logic           ovf_q, ovf_d;

    logic [2*N-1:0] dvd_abs_s;
    logic [N-1:0]   dsr_abs_s;
    logic [N-1:0]   quo_fix_s;
    logic [N-1:0]   rem_fix_s;
    logic           quo_neg_s;
    logic           ovf_s;
    logic [N+1:0]   part_sh_s;

    assign quo_neg_s = sgn_dvd_q ^ sgn_dsr_q;

    twos_abs #(.W(2 * N)) u_abs_dvd (
        .val_i (dividend),
        .neg_i (dividend[2*N-1]),
        .res_o (dvd_abs_s)
    );

    twos_abs #(.W(N)) u_abs_dsr (
        .val_i (divisor),
        .neg_i (divisor[N-1]),
        .res_o (dsr_abs_s)
    );

    // Only the low N bits matter: when they are used the magnitude has
    // already been proven to fit.
    twos_abs #(.W(N)) u_fix_quo (
        .val_i (quo_q[N-1:0]),
        .neg_i (quo_neg_s),
        .res_o (quo_fix_s)
    );

    twos_abs #(.W(N)) u_fix_rem (
        .val_i (part_q[N-1:0]),
        .neg_i (sgn_dvd_q),
        .res_o (rem_fix_s)
    );

    // Shifted partial remainder with the next dividend bit; one guard bit
    // above the N+1-bit register keeps the compare exact.
    assign part_sh_s = {part_q, dvd_q[2*N-1]};

    // Negative quotients may reach 2^(N-1), positive ones only 2^(N-1)-1.
    assign ovf_s = quo_q > (quo_neg_s ? LIM_NEG : LIM_POS);

    // Sequencer next state, datapath step and result formation.
    always_comb begin
        state_d   = state_q;
        sgn_dvd_d = sgn_dvd_q;
        sgn_dsr_d = sgn_dsr_q;
        zero_d    = zero_q;
        dvd_d     = dvd_q;
        quo_d     = quo_q;
        part_d    = part_q;
        dsr_d     = dsr_q;
        cnt_d     = cnt_q;
        done_d    = 1'b0;
        quot_d    = quot_q;
        rem_d     = rem_q;
        dbz_d     = dbz_q;
        ovf_d     = ovf_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    sgn_dvd_d = dividend[2*N-1];
                    sgn_dsr_d = divisor[N-1];
                    dvd_d     = dvd_abs_s;
                    dsr_d     = dsr_abs_s;
                    quo_d     = '0;
                    part_d    = '0;
                    cnt_d     = '0;
                    if (divisor == '0) begin
                        zero_d  = 1'b1;
                        state_d = S_FIX;
                    end else begin
                        zero_d  = 1'b0;
                        state_d = S_CALC;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end

            S_CALC: begin
                dvd_d = {dvd_q[2*N-2:0], 1'b0};
                cnt_d = cnt_q + CW'(1);
                if (part_sh_s >= {2'b00, dsr_q}) begin
                    part_d = part_sh_s[N:0] - {1'b0, dsr_q};
                    quo_d  = {quo_q[2*N-2:0], 1'b1};
                end else begin
                    part_d = part_sh_s[N:0];
                    quo_d  = {quo_q[2*N-2:0], 1'b0};
                end
                if (cnt_q == CNT_LAST) begin
                    state_d = S_FIX;
                end else begin
                    state_d = S_CALC;
                end
            end

            S_FIX: begin
                state_d = S_IDLE;
                done_d  = 1'b1;
                if (zero_q) begin
                    quot_d = '0;
                    rem_d  = '0;
                    dbz_d  = 1'b1;
                    ovf_d  = 1'b0;
                end else if (ovf_s) begin
                    quot_d = '0;
                    rem_d  = '0;
                    dbz_d  = 1'b0;
                    ovf_d  = 1'b1;
                end else begin
                    quot_d = quo_fix_s;
                    rem_d  = rem_fix_s;
                    dbz_d  = 1'b0;
                    ovf_d  = 1'b0;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State, datapath and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            sgn_dvd_q <= 1'b0;
            sgn_dsr_q <= 1'b0;
            zero_q    <= 1'b0;
            dvd_q     <= '0;
            quo_q     <= '0;
            part_q    <= '0;
            dsr_q     <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            quot_q    <= '0;
            rem_q     <= '0;
            dbz_q     <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            sgn_dvd_q <= sgn_dvd_d;
            sgn_dsr_q <= sgn_dsr_d;
            zero_q    <= zero_d;
            dvd_q     <= dvd_d;
            quo_q     <= quo_d;
            part_q    <= part_d;
            dsr_q     <= dsr_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            quot_q    <= quot_d;
            rem_q     <= rem_d;
            dbz_q     <= dbz_d;
            ovf_q     <= ovf_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quot_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;
    assign overflow    = ovf_q;

endmodule : booth_div

// File: tb/tb_booth_div.sv
// ---------------------------------------------------------------------------
// tb_booth_div
// Self-checking bench for booth_div (N=6). Expected results come from plain
// integer division on the signed operands.
// ---------------------------------------------------------------------------
module tb_booth_div;

    localparam int N = 6;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic [2*N-1:0] dividend;
    logic [N-1:0]   divisor;
    logic           busy;
    logic           done;
    logic [N-1:0]   quotient;
    logic [N-1:0]   remainder;
    logic           div_by_zero;
    logic           overflow;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    booth_div #(.N(N)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .overflow    (overflow)
    );

    // Single comparison point for the whole bench.
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    // Reference: truncating signed division, remainder follows dividend.
    task automatic model(input logic signed [2*N-1:0] a, input logic signed [N-1:0] b,
                         output logic [N-1:0] eq, output logic [N-1:0] er,
                         output logic edz, output logic eov);
        int ai, bi, q, r;
        ai = a;
        bi = b;
        if (bi == 0) begin
            eq = '0; er = '0; edz = 1'b1; eov = 1'b0;
        end else begin
            q   = ai / bi;
            r   = ai % bi;
            edz = 1'b0;
            eov = (q < -32) || (q > 31);
            eq  = eov ? 6'd0 : q[N-1:0];
            er  = eov ? 6'd0 : r[N-1:0];
        end
    endtask

    // One operation; inj>0 pulses a spurious start at that cycle.
    task automatic run_op(input logic [2*N-1:0] a, input logic [N-1:0] b,
                          input int inj, input string tag);
        logic [N-1:0] eq, er;
        logic         edz, eov;
        int           lat;
        model(a, b, eq, er, edz, eov);
        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat   = 1;
        check($sformatf("%s.busy_after_accept", tag), 32'(busy), 32'd1);
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
            if (lat == inj) begin
                start    = 1'b1;
                dividend = 12'($urandom);
                divisor  = 6'd1;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        check($sformatf("%s.latency", tag), 32'(lat), edz ? 32'd2 : 32'd14);
        check($sformatf("%s.quotient", tag), 32'(quotient), 32'(eq));
        check($sformatf("%s.remainder", tag), 32'(remainder), 32'(er));
        check($sformatf("%s.div_by_zero", tag), 32'(div_by_zero), 32'(edz));
        check($sformatf("%s.overflow", tag), 32'(overflow), 32'(eov));
        check($sformatf("%s.busy_in_done", tag), 32'(busy), 32'd0);
        @(negedge clk);
        check($sformatf("%s.done_pulse", tag), 32'(done), 32'd0);
        check($sformatf("%s.quotient_hold", tag), 32'(quotient), 32'(eq));
    endtask

    // Held start: two operations back to back, exactly 14 cycles apart.
    task automatic run_b2b();
        logic [N-1:0] eq1, er1, eq2, er2;
        logic         dz1, ov1, dz2, ov2;
        int           cnt;
        model(12'(-365), 6'(-12), eq1, er1, dz1, ov1);
        model(12'd100, 6'(-7), eq2, er2, dz2, ov2);
        @(negedge clk);
        dividend = 12'(-365);
        divisor  = 6'(-12);
        start    = 1'b1;
        @(negedge clk);
        dividend = 12'd100;
        divisor  = 6'(-7);
        cnt = 1;
        while (!done && cnt < 40) begin
            @(negedge clk);
            cnt++;
        end
        check("b2b.first_latency", 32'(cnt), 32'd14);
        check("b2b.first_quotient", 32'(quotient), 32'(eq1));
        check("b2b.first_remainder", 32'(remainder), 32'(er1));
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
            if (cnt == 1) start = 1'b0;
        end while (!done && cnt < 40);
        check("b2b.spacing", 32'(cnt), 32'd14);
        check("b2b.second_quotient", 32'(quotient), 32'(eq2));
        check("b2b.second_remainder", 32'(remainder), 32'(er2));
        @(negedge clk);
        check("b2b.done_low", 32'(done), 32'd0);
    endtask

    // Reset mid-operation: everything clears and no done appears.
    task automatic run_reset_abort();
        int n_done;
        @(negedge clk);
        dividend = 12'(-360);
        divisor  = 6'(-12);
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_mid.busy", 32'(busy), 32'd0);
        check("rst_mid.done", 32'(done), 32'd0);
        check("rst_mid.quotient", 32'(quotient), 32'd0);
        check("rst_mid.remainder", 32'(remainder), 32'd0);
        check("rst_mid.div_by_zero", 32'(div_by_zero), 32'd0);
        check("rst_mid.overflow", 32'(overflow), 32'd0);
        n_done = 0;
        repeat (20) begin
            @(negedge clk);
            if (done) n_done++;
        end
        check("rst_mid.no_done", 32'(n_done), 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2*N-1:0] a;
        logic [N-1:0]   b, x;

        rst      = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (3) @(negedge clk);
        check("reset.busy", 32'(busy), 32'd0);
        check("reset.done", 32'(done), 32'd0);
        check("reset.quotient", 32'(quotient), 32'd0);
        check("reset.remainder", 32'(remainder), 32'd0);
        check("reset.div_by_zero", 32'(div_by_zero), 32'd0);
        check("reset.overflow", 32'(overflow), 32'd0);
        rst = 1'b0;

        run_op(12'hE98, 6'b110100, 0, "m360_m12");
        run_op(12'(-365), 6'(-12), 0, "m365_m12");
        run_op(12'd100, 6'(-7), 0, "p100_m7");
        run_op(12'(-100), 6'd7, 0, "m100_p7");
        run_op(12'(-1024), 6'd32, 0, "m1024_p32");
        run_op(12'(-1024), 6'(-32), 0, "m1024_m32_ovf");
        run_op(12'd2000, 6'd3, 0, "p2000_p3_ovf");
        run_op(12'h800, 6'h20, 0, "minmin");
        run_op(12'd123, 6'd0, 0, "divzero");
        run_op(12'd100, 6'd7, 0, "after_divzero");
        run_op(12'd100, 6'd7, 5, "inject");
        run_b2b();
        run_reset_abort();
        run_op(12'd100, 6'd7, 0, "after_reset");

        for (int i = 0; i < 150; i++) begin
            b = 6'($urandom);
            if (i % 2 == 0) begin
                x = 6'($urandom);
                a = {{N{x[N-1]}}, x};
            end else begin
                a = 12'($urandom);
            end
            if (i % 10 == 0) b = 6'd0;
            if (i % 17 == 0) a = 12'h800;
            run_op(a, b, 0, $sformatf("rand%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_booth_div
